// File: rtl/filt_threshold_detector.sv
// Hysteresis threshold detector on a filtered sample stream with run-length
// qualification, post-event holdoff and a saturating event counter.
// Optional peak-magnitude capture is built when FILT_PEAK_CAPTURE_EN is defined.
//
// Handshake: en is a one-cycle sample strobe. X and the configuration inputs
// are consumed only in cycles with en=1. There is no back-pressure.
module filt_threshold_detector #(
    parameter int N  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  X,
    input  logic [N-1:0]  thr_hi,
    input  logic [N-1:0]  thr_lo,
    input  logic [CW-1:0] min_len,
    input  logic [CW-1:0] holdoff,
    input  logic          clr,
    output logic          detect,
    output logic          active,
    output logic [CW-1:0] evt_cnt,
    output logic [N-1:0]  peak,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CAND   = 2'd1,
        DETECT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [N-1:0]  MOST_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  MAX_POS  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] run;
    logic [CW-1:0] run_nxt;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] hcnt_nxt;
    logic [CW-1:0] min_eff;
    logic [CW:0]   run_inc;
    logic [N-1:0]  mag;
    logic          enter_det;

    // -2^(N-1) has no positive counterpart, so it clips to the largest positive value.
    always_comb begin
        if (X == MOST_NEG) begin
            mag = MAX_POS;
        end else if (X[N-1]) begin
            mag = ~X + ONE_N;
        end else begin
            mag = X;
        end
    end

    assign min_eff = (min_len == '0) ? ONE_C : min_len;
    assign run_inc = {1'b0, run} + {{CW{1'b0}}, 1'b1};

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        hcnt_nxt  = hcnt;
        enter_det = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (mag >= thr_hi) begin
                        if (min_eff == ONE_C) begin
                            state_nxt = DETECT;
                            run_nxt   = '0;
                            enter_det = 1'b1;
                        end else begin
                            state_nxt = CAND;
                            run_nxt   = ONE_C;
                        end
                    end
                end
                CAND: begin
                    if (mag >= thr_lo) begin
                        // >= rather than == so a mid-run drop of min_len still confirms.
                        if (run_inc >= {1'b0, min_eff}) begin
                            state_nxt = DETECT;
                            run_nxt   = '0;
                            enter_det = 1'b1;
                        end else begin
                            run_nxt = run_inc[CW-1:0];
                        end
                    end else begin
                        state_nxt = IDLE;
                        run_nxt   = '0;
                    end
                end
                DETECT: begin
                    if (mag < thr_lo) begin
                        if (holdoff == '0) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = HOLD;
                            hcnt_nxt  = holdoff;
                        end
                    end
                end
                HOLD: begin
                    if (hcnt <= ONE_C) begin
                        state_nxt = IDLE;
                        hcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt = hcnt - ONE_C;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    run_nxt   = '0;
                    hcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            run    <= '0;
            hcnt   <= '0;
            detect <= 1'b0;
        end else begin
            state  <= state_nxt;
            run    <= run_nxt;
            hcnt   <= hcnt_nxt;
            detect <= enter_det;
        end
    end

    // The count moves on the same edge that raises detect, so a clr in the
    // confirming en cycle leaves exactly that one event counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (clr) begin
            evt_cnt <= enter_det ? ONE_C : '0;
        end else if (enter_det && (evt_cnt != CNT_MAX)) begin
            evt_cnt <= evt_cnt + ONE_C;
        end
    end

    assign active    = (state == DETECT);
    assign state_dbg = state;

`ifdef FILT_PEAK_CAPTURE_EN
    logic [N-1:0] peak_q;
    logic         peak_upd;

    assign peak_upd = en && (mag > peak_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else if (peak_upd) begin
            peak_q <= mag;
        end else if (clr) begin
            peak_q <= '0;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_filt_threshold_detector.sv
// Self-checking bench for filt_threshold_detector: directed scenarios with
// literal expectations, then randomized traffic against a sample-level model.
module tb_filt_threshold_detector;

  localparam int N  = 16;
  localparam int CW = 8;
  localparam int CNT_TOP = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic [N-1:0]  X;
  logic [N-1:0]  thr_hi;
  logic [N-1:0]  thr_lo;
  logic [CW-1:0] min_len;
  logic [CW-1:0] holdoff;
  logic          clr;
  logic          detect;
  logic          active;
  logic [CW-1:0] evt_cnt;
  logic [N-1:0]  peak;
  logic [1:0]    state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  filt_threshold_detector #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .X         (X),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .min_len   (min_len),
    .holdoff   (holdoff),
    .clr       (clr),
    .detect    (detect),
    .active    (active),
    .evt_cnt   (evt_cnt),
    .peak      (peak),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the detector at sample granularity: what phase of an event the
  // stream is in, how many qualifying samples so far, how many samples of
  // holdoff remain.
  localparam int PH_QUIET = 0, PH_BUILD = 1, PH_EVENT = 2, PH_BLANK = 3;
  int m_phase, m_run, m_left;
  int m_detect, m_active, m_cnt, m_peak;

  function automatic int magnitude(input logic [N-1:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  always @(posedge clk) begin
    int mg, need;
    bit fired;
    if (rst) begin
      m_phase = PH_QUIET; m_run = 0; m_left = 0;
      m_detect = 0; m_cnt = 0; m_peak = 0;
    end else begin
      fired = 0;
      mg = magnitude(X);
      need = (min_len == 0) ? 1 : int'(min_len);
      if (en) begin
        case (m_phase)
          PH_QUIET: if (mg >= int'(thr_hi)) begin
            m_run = 1;
            if (m_run >= need) begin fired = 1; m_phase = PH_EVENT; m_run = 0; end
            else m_phase = PH_BUILD;
          end
          PH_BUILD: if (mg >= int'(thr_lo)) begin
            m_run = m_run + 1;
            if (m_run >= need) begin fired = 1; m_phase = PH_EVENT; m_run = 0; end
          end else begin
            m_phase = PH_QUIET; m_run = 0;
          end
          PH_EVENT: if (mg < int'(thr_lo)) begin
            if (holdoff == 0) m_phase = PH_QUIET;
            else begin m_phase = PH_BLANK; m_left = int'(holdoff); end
          end
          default: begin
            m_left = m_left - 1;
            if (m_left <= 0) begin m_phase = PH_QUIET; m_left = 0; end
          end
        endcase
      end
      m_detect = fired;
      if (clr) m_cnt = fired ? 1 : 0;
      else if (fired && m_cnt < CNT_TOP) m_cnt = m_cnt + 1;
      if (en && mg > m_peak) m_peak = mg;
      else if (clr) m_peak = 0;
    end
    m_active = (m_phase == PH_EVENT);
  end

  function automatic int exp_peak();
`ifdef FILT_PEAK_CAPTURE_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("detect", int'(detect), m_detect);
      check("active", int'(active), m_active);
      check("evt_cnt", int'(evt_cnt), m_cnt);
      check("peak", int'(peak), exp_peak());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] x);
    en = 1; X = x;
    @(posedge clk); #1;
    en = 0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
  endtask

  task automatic do_rst();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic set_cfg(input int hi, input int lo, input int ml, input int ho);
    thr_hi = N'(hi); thr_lo = N'(lo); min_len = CW'(ml); holdoff = CW'(ho);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; en = 0; clr = 0; X = '0;
    set_cfg(100, 60, 3, 2);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    chk_on = 1;

    // reset state
    check("rst_detect", int'(detect), 0);
    check("rst_active", int'(active), 0);
    check("rst_evt_cnt", int'(evt_cnt), 0);
    check("rst_peak", int'(peak), 0);
    check("rst_state", int'(state_dbg), 0);

    // basic event: 120,80,70 confirms, 10 ends it
    send(16'd120); check("ev1_no_det_1", int'(detect), 0);
    send(16'd80);  check("ev1_no_det_2", int'(detect), 0);
    send(16'd70);
    check("ev1_detect", int'(detect), 1);
    check("ev1_active", int'(active), 1);
    check("ev1_evt_cnt", int'(evt_cnt), 1);
    gap(1);
    check("ev1_pulse_once", int'(detect), 0);
    check("ev1_still_active", int'(active), 1);
    send(16'd10);
    check("ev1_active_low", int'(active), 0);

    // samples in holdoff are ignored, then a fresh event
    send(16'd200); send(16'd200);
    check("hold_ignored", int'(detect), 0);
    send(16'd200); send(16'd200); send(16'd200);
    check("ev2_detect", int'(detect), 1);
    check("ev2_evt_cnt", int'(evt_cnt), 2);
    send(16'd10); send(16'd0); send(16'd0);

    // candidate run that dies
    do_clr();
    check("clr_evt_cnt", int'(evt_cnt), 0);
    send(16'd120); send(16'd50);
    check("abort_state", int'(state_dbg), 0);
    check("abort_detect", int'(detect), 0);
    check("abort_evt_cnt", int'(evt_cnt), 0);

    // most negative sample saturates
    set_cfg(16'h7FFF, 16'h7FFF, 1, 2);
    send(16'h8000);
    check("neg_detect", int'(detect), 1);
`ifdef FILT_PEAK_CAPTURE_EN
    check("neg_peak", int'(peak), 32767);
`else
    check("neg_peak", int'(peak), 0);
`endif
    send(16'd0); send(16'd0); send(16'd0);

    // saturation of evt_cnt
    set_cfg(100, 60, 1, 0);
    do_rst();
    for (int k = 0; k < CNT_TOP + 1; k++) begin
      send(16'd200); send(16'd0);
    end
    check("sat_evt_cnt", int'(evt_cnt), CNT_TOP);
    do_clr();
    check("clr_sat_cnt", int'(evt_cnt), 0);
    check("clr_peak", int'(peak), 0);

    // reset in the middle of a candidate run overrides en
    set_cfg(100, 60, 3, 2);
    send(16'd120); send(16'd80);
    rst = 1; en = 1; X = 16'd70;
    @(posedge clk); #1;
    rst = 0; en = 0;
    check("mid_rst_state", int'(state_dbg), 0);
    check("mid_rst_detect", int'(detect), 0);
    check("mid_rst_active", int'(active), 0);
    check("mid_rst_evt_cnt", int'(evt_cnt), 0);
    check("mid_rst_peak", int'(peak), 0);

    // same event with 10-clock gaps between samples
    send(16'd120); gap(10);
    send(16'd80);  gap(10);
    send(16'd70);
    check("gap_detect", int'(detect), 1);
    check("gap_evt_cnt", int'(evt_cnt), 1);
    gap(10);
    check("gap_pulse_once", int'(detect), 0);
    check("gap_active_held", int'(active), 1);
    send(16'd10);
    check("gap_active_low", int'(active), 0);
    send(16'd0); send(16'd0);

    // randomized traffic, checked by the compare process every cycle
    for (int i = 0; i < 4000; i++) begin
      logic [N-1:0] t;
      if (i % 200 == 0)
        set_cfg($urandom_range(50, 300), $urandom_range(20, 300),
                $urandom_range(0, 4), $urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        t = 16'h8000;
      end else begin
        t = N'($urandom_range(0, 350));
        if ($urandom_range(0, 1) == 1) t = ~t + 16'd1;
      end
      X = t;
      @(posedge clk); #1;
    end
    rst = 0; clr = 0; en = 0;
    gap(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/filt_threshold_detector.md
FILT_THRESHOLD_DETECTOR -- requirements
Module: filt_threshold_detector

Interface
REQ-001 SHALL have parameter N, default 16, sample and threshold width in bits.
REQ-002 SHALL have parameter CW, default 8, width of the run, holdoff and event counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1, sample strobe from the upstream FIR/IIR stage; X is valid in any cycle where en=1.
REQ-006 SHALL have port X, input, N, filter output sample, signed two's complement.
REQ-007 SHALL have port thr_hi, input, N, unsigned magnitude threshold that starts a candidate run.
REQ-008 SHALL have port thr_lo, input, N, unsigned magnitude threshold that sustains a run (hysteresis).
REQ-009 SHALL have port min_len, input, CW, number of qualifying samples that confirm an event.
REQ-010 SHALL have port holdoff, input, CW, number of samples ignored after an event ends.
REQ-011 SHALL have port clr, input, 1, one-cycle clear of evt_cnt and peak.
REQ-012 SHALL have port detect, output, 1, one-cycle pulse on event confirmation.
REQ-013 SHALL have port active, output, 1, high while in DETECT.
REQ-014 SHALL have port evt_cnt, output, CW, saturating count of confirmed events.
REQ-015 SHALL have port peak, output, N, largest magnitude seen since the last clr or rst (see Configuration).

Function
REQ-016 SHALL compute mag = |X|, with the most negative value (-2^(N-1)) saturating to 2^(N-1)-1.
REQ-017 SHALL evaluate state only in cycles with en=1; in cycles with en=0, state and counters hold and detect=0.
REQ-018 SHALL implement the FSM states IDLE, CAND, DETECT and HOLD.
REQ-019 IDLE: on en with mag>=thr_hi, SHALL go to CAND with run=1; if the effective min_len<=1, it SHALL go directly to DETECT instead.
REQ-020 CAND: on en with mag>=thr_lo, SHALL increment run; when run reaches min_len, SHALL go to DETECT. On en with mag<thr_lo, SHALL go to IDLE with run=0.
REQ-021 DETECT: SHALL stay while mag>=thr_lo; on en with mag<thr_lo, SHALL go to HOLD and load hcnt=holdoff; if holdoff=0, SHALL go to IDLE instead.
REQ-022 HOLD: on each en, SHALL decrement hcnt and ignore mag; when hcnt reaches 0, SHALL go to IDLE.
REQ-023 SHALL treat min_len=0 as 1.
REQ-024 SHALL assert detect exactly one clock after the en cycle that causes entry to DETECT, with latency 1; active SHALL rise in that same cycle.
REQ-025 SHALL increment evt_cnt on each detect and hold it at 2^CW-1.
REQ-026 When clr and detect occur in the same cycle, evt_cnt SHALL become 1.
REQ-027 When clr and a peak update occur in the same cycle, peak SHALL take the new mag.
REQ-028 SHALL sample thr_hi, thr_lo, min_len and holdoff on each en; changes mid-run SHALL take effect at the next en.
REQ-029 SHALL use unsigned comparisons; if thr_lo>thr_hi, a run SHALL end on the first sample below thr_lo.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, run=0, hcnt=0, detect=0, active=0, evt_cnt=0, peak=0.
REQ-031 rst SHALL override en and clr; a reset mid-event SHALL produce no detect pulse.

Configuration
REQ-032 Macro FILT_PEAK_CAPTURE_EN defined: peak SHALL update to mag on any en where mag>peak, in any state.
REQ-033 Macro FILT_PEAK_CAPTURE_EN undefined: peak SHALL be tied to 0 with no peak register; all other behaviour SHALL be unchanged.

Verification
REQ-034 thr_hi=100, thr_lo=60, min_len=3, holdoff=2; samples 120,80,70,10 -> detect pulse one clk after the 70 sample; active until the 10 sample; evt_cnt=1.
REQ-035 Same config; samples 120,50 -> returns to IDLE; no detect; evt_cnt=0.
REQ-036 After the REQ-034 event, samples 200,200 arriving in HOLD -> ignored; a following 200,200,200 -> second detect; evt_cnt=2.
REQ-037 X=16'h8000 with thr_hi=16'h7FFF and min_len=1 -> detect; peak=16'h7FFF when FILT_PEAK_CAPTURE_EN is defined, peak=0 when it is undefined.
REQ-038 evt_cnt=255 plus one more event -> stays 255; clr asserted with no event -> evt_cnt=0 and peak=0.
REQ-039 rst pulsed while in CAND with run=2 -> state=IDLE and all outputs 0 at the next clock; en gaps of 10 clocks between samples -> identical results.
